ccd_core: RTL and testbench
===========================

# ccd_core

Parametrised successor to the 4-bit microcoded CPU top, packaged as one self-contained multicycle accumulator processor. It fetches instructions from an external instruction memory, executes them over an accumulator and a register file, and exchanges data with peripherals over an I/O port. The port uses a ready/ack handshake with a timeout. Carry and zero flags are architecturally visible. It sits at the top of the processing subsystem, between instruction ROM and peripheral port decoders.

## Interface
Parameters:
- DATA_W, 4: accumulator, register and port data width.
- REG_AW, 3: register-file address width (2**REG_AW registers).
- PC_W, 4: program counter width; must be ≤ DATA_W.
- PORT_ID_W, 3: port ID width; must be ≤ DATA_W.
- IO_TIMEOUT, 15: maximum cycles waiting for port_ack; ≥ 1.
- INSTR_W derived: 4 + REG_AW + DATA_W.

Ports:
- clk, in, 1: the single clock.
- reset, in, 1: synchronous, active-high.
- imem_addr, out, PC_W: fetch address (= PC).
- imem_data, in, INSTR_W: combinational instruction read data; fields are [opcode 4 | reg REG_AW | imm DATA_W].
- port_din, in, DATA_W: peripheral read data.
- port_dout, out, DATA_W: peripheral write data (= A).
- port_id, out, PORT_ID_W: imm[PORT_ID_W-1:0] of the current I/O instruction.
- port_rd, out, 1: read request, held until ack or timeout.
- port_wr, out, 1: write request, held until ack or timeout.
- port_ack, in, 1: peripheral completion strobe.
- carry_flag, out, 1: C flag.
- zero_flag, out, 1: Z flag.
- io_err, out, 1: sticky; set on timeout.
- halted, out, 1: high in HALT state.

## Operation
- Opcodes (R = R[reg], imm = immediate):
  - 0 NOP.
  - 1 LDI: A←imm.
  - 2 MOV: A←R.
  - 3 ST: R←A.
  - 4 ADD: A←A+R, C=carry-out.
  - 5 SUB: A←A−R, C=borrow (A<R).
  - 6 AND.
  - 7 OR.
  - 8 HALT.
  - 9 SHL: C=A[msb], A←A<<1.
  - A SHR: C=A[0], A←A>>1.
  - B IN: A←port_din.
  - C OUT.
  - D JMP imm.
  - E JZ imm (if Z).
  - F JC imm (if C).
- Arithmetic is DATA_W-bit, wrap-around modulo 2**DATA_W. The carry is bit DATA_W of the (DATA_W+1)-bit result.
- Z ← (new A == 0) on every A write: LDI, MOV, ADD, SUB, AND, OR, SHL, SHR, successful IN. All other instructions leave Z unchanged.
- C changes only on ADD/SUB/SHL/SHR.
- Jump targets are imm[PC_W-1:0]. The PC wraps from 2**PC_W−1 to 0.
- FSM states FETCH, EXEC, IO_WAIT, HALT:
  - FETCH: latch imem_data into IR; → EXEC.
  - EXEC: non-I/O instruction: commit the result, PC ← PC+1 or jump target; → FETCH. HALT opcode → HALT. IN/OUT → IO_WAIT.
  - IO_WAIT: port_rd (IN) or port_wr (OUT) held high, port_id stable.
    - port_ack: IN loads A and updates Z; PC+1; → FETCH.
    - Timeout (IO_TIMEOUT cycles without ack): io_err←1, A/Z unchanged, PC+1; → FETCH.
    - Ack on the final timeout cycle counts as success.
  - HALT: stays there until reset.
- Reset values: PC=0, A=0, all R=0, C=0, Z=0, io_err=0, state FETCH, port_rd=port_wr=0, imem_addr=0, port_dout=0, port_id=0, halted=0.
- Reset mid-IO_WAIT drops port_rd/port_wr in the next cycle and does not set io_err.

## Timing
- Non-I/O instruction: 2 cycles (FETCH+EXEC).
- I/O instruction: 3+k cycles, where k = cycles in IO_WAIT before the ack cycle (k ≤ IO_TIMEOUT−1). A timed-out I/O instruction takes 2+IO_TIMEOUT cycles.
- All state updates happen on the posedge ending EXEC, or the ack/timeout cycle.
- Flags are visible the following cycle.
- All outputs are registered or derived from registered state; no combinational path from input to output.
- port_ack is ignored outside IO_WAIT.

## Structure
- Package ccd_pkg: opcode enum, FSM state enum, field-slice constants/functions for the IR.
- One sub-module, ccd_alu: combinational, DATA_W-parametrised. Inputs: A, operand, op. Outputs: result, carry, zero.
- Register file, PC, flags and FSM live in ccd_core.

## Test plan
- Reset, then LDI 9; LDI 9/ADD R0 with R0=9 (via ST): A=2 (DATA_W=4), C=1, Z=0.
- LDI 3; ST R1; LDI 3; SUB R1 → A=0, Z=1, C=0; then JZ 0xA → imem_addr=0xA on the next FETCH.
- OUT id 5 with ack after 3 cycles: port_wr high for exactly 4 cycles, port_id=5, port_dout=A; io_err=0.
- IN with no ack, IO_TIMEOUT=15: port_rd high for 15 cycles, then io_err=1, A unchanged, execution continues at PC+1.
- Reset asserted in the 2nd IO_WAIT cycle: port_rd=0 and PC=0 the next cycle, io_err stays 0.
- PC=15 executing NOP: next fetch at 0. HALT: halted=1, imem_addr frozen for 20 cycles.

Source files
------------

// File: rtl/ccd_pkg.sv
// Shared types and instruction-field helpers for the ccd accumulator processor.
package ccd_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_MOV  = 4'h2,
    OP_ST   = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_HALT = 4'h8,
    OP_SHL  = 4'h9,
    OP_SHR  = 4'hA,
    OP_IN   = 4'hB,
    OP_OUT  = 4'hC,
    OP_JMP  = 4'hD,
    OP_JZ   = 4'hE,
    OP_JC   = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXEC    = 2'd1,
    ST_IO_WAIT = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  // IR layout is [opcode | reg | imm], imm in the low bits.
  function automatic int instr_width(input int reg_aw, input int data_w);
    return OPC_W + reg_aw + data_w;
  endfunction

  function automatic int opc_lsb(input int reg_aw, input int data_w);
    return reg_aw + data_w;
  endfunction

  function automatic int reg_lsb(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/ccd_alu.sv
// Combinational datapath for accumulator instructions; carry is bit DATA_W of the wide result.
module ccd_alu
  import ccd_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  opcode_e           op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o,
  output logic              zero_o
);

  logic [DATA_W:0] sum;

  always_comb begin
    result_o = b_i;
    carry_o  = 1'b0;
    sum      = '0;
    case (op_i)
      OP_ADD: begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        result_o = sum[DATA_W-1:0];
        carry_o  = sum[DATA_W];
      end
      OP_SUB: begin
        // bit DATA_W of the wide difference is the borrow (a < b)
        sum      = {1'b0, a_i} - {1'b0, b_i};
        result_o = sum[DATA_W-1:0];
        carry_o  = sum[DATA_W];
      end
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_SHL: {carry_o, result_o} = {a_i, 1'b0};
      OP_SHR: {result_o, carry_o} = {1'b0, a_i};
      default: result_o = b_i;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/ccd_core.sv
// Multicycle accumulator processor: fetch/execute FSM, register file, flags and I/O port handshake.
//   state      | meaning
//   ST_FETCH   | latch imem_data into IR
//   ST_EXEC    | commit non-I/O result, advance or jump PC
//   ST_IO_WAIT | hold port_rd/port_wr until ack or timeout
//   ST_HALT    | parked until reset
module ccd_core
  import ccd_pkg::*;
#(
  parameter  int DATA_W     = 4,
  parameter  int REG_AW     = 3,
  parameter  int PC_W       = 4,
  parameter  int PORT_ID_W  = 3,
  parameter  int IO_TIMEOUT = 15,
  localparam int INSTR_W    = instr_width(REG_AW, DATA_W)
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [PC_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]   imem_data,
  input  logic [DATA_W-1:0]    port_din,
  output logic [DATA_W-1:0]    port_dout,
  output logic [PORT_ID_W-1:0] port_id,
  output logic                 port_rd,
  output logic                 port_wr,
  input  logic                 port_ack,
  output logic                 carry_flag,
  output logic                 zero_flag,
  output logic                 io_err,
  output logic                 halted
);

  localparam int NREG    = 2 ** REG_AW;
  localparam int TMR_W   = $clog2(IO_TIMEOUT + 1);
  localparam int OPC_LSB = opc_lsb(REG_AW, DATA_W);
  localparam int REG_LSB = reg_lsb(DATA_W);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic                c_q, c_d, z_q, z_d, err_q, err_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [DATA_W-1:0]   rf_q [NREG];
  logic                rf_we;

  opcode_e             opc;
  logic [REG_AW-1:0]   rsel;
  logic [DATA_W-1:0]   imm, rval, alu_b, alu_res;
  logic                alu_c, alu_z;
  logic [PC_W-1:0]     pc_inc, jmp_tgt;

  assign opc     = opcode_e'(ir_q[OPC_LSB +: OPC_W]);
  assign rsel    = ir_q[REG_LSB +: REG_AW];
  assign imm     = ir_q[DATA_W-1:0];
  assign rval    = rf_q[rsel];
  assign pc_inc  = pc_q + 1'b1;
  assign jmp_tgt = imm[PC_W-1:0];
  assign alu_b   = (opc == OP_LDI) ? imm : (opc == OP_IN) ? port_din : rval;

  ccd_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i      (a_q),
    .b_i      (alu_b),
    .op_i     (opc),
    .result_o (alu_res),
    .carry_o  (alu_c),
    .zero_o   (alu_z)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    c_d     = c_q;
    z_d     = z_q;
    err_d   = err_q;
    ir_d    = ir_q;
    tmr_d   = tmr_q;
    rf_we   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_d    = imem_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        case (opc)
          OP_LDI, OP_MOV, OP_AND, OP_OR: begin
            a_d = alu_res;
            z_d = alu_z;
          end
          OP_ADD, OP_SUB, OP_SHL, OP_SHR: begin
            a_d = alu_res;
            z_d = alu_z;
            c_d = alu_c;
          end
          OP_ST: rf_we = 1'b1;
          OP_HALT: begin
            state_d = ST_HALT;
            pc_d    = pc_q;
          end
          OP_IN, OP_OUT: begin
            // PC advances only once the transfer completes or times out
            state_d = ST_IO_WAIT;
            pc_d    = pc_q;
            tmr_d   = TMR_W'(IO_TIMEOUT - 1);
          end
          OP_JMP: pc_d = jmp_tgt;
          OP_JZ:  if (z_q) pc_d = jmp_tgt;
          OP_JC:  if (c_q) pc_d = jmp_tgt;
          default: ;
        endcase
      end
      ST_IO_WAIT: begin
        // ack wins over timeout, including on the final countdown cycle
        if (port_ack) begin
          if (opc == OP_IN) begin
            a_d = alu_res;
            z_d = alu_z;
          end
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end else if (tmr_q == '0) begin
          err_d   = 1'b1;
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      a_q     <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      err_q   <= 1'b0;
      ir_q    <= '0;
      tmr_q   <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      c_q     <= c_d;
      z_q     <= z_d;
      err_q   <= err_d;
      ir_q    <= ir_d;
      tmr_q   <= tmr_d;
      if (rf_we) rf_q[rsel] <= a_q;
    end
  end

  assign imem_addr  = pc_q;
  assign port_dout  = a_q;
  assign port_id    = imm[PORT_ID_W-1:0];
  assign port_rd    = (state_q == ST_IO_WAIT) && (opc == OP_IN);
  assign port_wr    = (state_q == ST_IO_WAIT) && (opc == OP_OUT);
  assign carry_flag = c_q;
  assign zero_flag  = z_q;
  assign io_err     = err_q;
  assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_ccd_core.sv
// Directed self-checking bench for ccd_core with default parameters.
module tb_ccd_core;

  localparam int DATA_W = 4, REG_AW = 3, PC_W = 4, PORT_ID_W = 3, IO_TIMEOUT = 15;
  localparam int INSTR_W = 4 + REG_AW + DATA_W;

  localparam logic [3:0] NOP = 4'h0, LDI = 4'h1, MOV = 4'h2, ST = 4'h3, ADD = 4'h4,
                         SUB = 4'h5, AND = 4'h6, OR = 4'h7, HLT = 4'h8, SHL = 4'h9,
                         SHR = 4'hA, IN = 4'hB, OUT = 4'hC, JMP = 4'hD, JZ = 4'hE, JC = 4'hF;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [PC_W-1:0]      imem_addr;
  logic [INSTR_W-1:0]   imem_data;
  logic [DATA_W-1:0]    port_din = '0;
  logic [DATA_W-1:0]    port_dout;
  logic [PORT_ID_W-1:0] port_id;
  logic                 port_rd, port_wr;
  logic                 port_ack = 1'b0;
  logic                 carry_flag, zero_flag, io_err, halted;

  logic [INSTR_W-1:0]   imem [16];
  int checks = 0;
  int fails  = 0;

  assign imem_data = imem[imem_addr];

  always #5 clk = ~clk;

  ccd_core #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .PC_W(PC_W),
    .PORT_ID_W(PORT_ID_W), .IO_TIMEOUT(IO_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .port_din(port_din), .port_dout(port_dout), .port_id(port_id),
    .port_rd(port_rd), .port_wr(port_wr), .port_ack(port_ack),
    .carry_flag(carry_flag), .zero_flag(zero_flag), .io_err(io_err), .halted(halted)
  );

  function automatic logic [INSTR_W-1:0] ins(input logic [3:0] op, input logic [2:0] r,
                                             input logic [3:0] imm);
    return {op, r, imm};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 16; i++) imem[i] = ins(NOP, 3'd0, 4'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts cycles with a port request active; pulses ack during request cycle ack_at (0 = never).
  task automatic run_io(input int ack_at, input logic [2:0] exp_id, input logic is_wr,
                        output int cnt, output logic ok);
    cnt = 0;
    ok  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (port_rd || port_wr) begin
        cnt++;
        if (port_id !== exp_id || port_wr !== is_wr || port_rd !== !is_wr) ok = 1'b0;
      end else if (cnt > 0) begin
        break;
      end
      port_ack = (ack_at != 0) && (cnt == ack_at);
      @(negedge clk);
    end
    port_ack = 1'b0;
  endtask

  task automatic test_reset();
    clear_imem();
    reset = 1'b1;
    step(3);
    checks++; if ({port_rd, port_wr, halted, io_err, carry_flag, zero_flag} !== 6'b0) begin
      fails++; $display("FAIL reset_ctl: got %b expected 000000",
                        {port_rd, port_wr, halted, io_err, carry_flag, zero_flag}); end
    checks++; if (imem_addr !== 4'h0) begin
      fails++; $display("FAIL reset_pc: got %0h expected 0", imem_addr); end
    checks++; if (port_dout !== 4'h0) begin
      fails++; $display("FAIL reset_a: got %0h expected 0", port_dout); end
    checks++; if (port_id !== 3'h0) begin
      fails++; $display("FAIL reset_id: got %0h expected 0", port_id); end
    reset = 1'b0;
  endtask

  task automatic test_add();
    logic frozen;
    clear_imem();
    imem[0] = ins(LDI, 3'd0, 4'h9);
    imem[1] = ins(ST,  3'd0, 4'h0);
    imem[2] = ins(LDI, 3'd0, 4'h9);
    imem[3] = ins(ADD, 3'd0, 4'h0);
    imem[4] = ins(HLT, 3'd0, 4'h0);
    imem[5] = ins(LDI, 3'd0, 4'h1);
    do_reset();
    step(2);
    checks++; if (port_dout !== 4'h9) begin
      fails++; $display("FAIL add_ldi: got %0h expected 9", port_dout); end
    step(6);
    checks++; if ({port_dout, carry_flag, zero_flag} !== {4'h2, 1'b1, 1'b0}) begin
      fails++; $display("FAIL add_result: got A=%0h C=%b Z=%b expected A=2 C=1 Z=0",
                        port_dout, carry_flag, zero_flag); end
    step(2);
    checks++; if (halted !== 1'b1) begin
      fails++; $display("FAIL halt_enter: got %b expected 1", halted); end
    frozen = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (imem_addr !== 4'h4 || halted !== 1'b1 || port_dout !== 4'h2) frozen = 1'b0;
    end
    checks++; if (frozen !== 1'b1) begin
      fails++; $display("FAIL halt_frozen: got pc=%0h halted=%b expected pc=4 halted=1",
                        imem_addr, halted); end
  endtask

  task automatic test_sub_jz();
    clear_imem();
    imem[0]  = ins(LDI, 3'd0, 4'h3);
    imem[1]  = ins(ST,  3'd1, 4'h0);
    imem[2]  = ins(LDI, 3'd0, 4'hF);
    imem[3]  = ins(SHL, 3'd0, 4'h0);
    imem[4]  = ins(LDI, 3'd0, 4'h3);
    imem[5]  = ins(SUB, 3'd1, 4'h0);
    imem[6]  = ins(JZ,  3'd0, 4'hA);
    imem[10] = ins(LDI, 3'd0, 4'h1);
    imem[11] = ins(SUB, 3'd1, 4'h0);
    imem[12] = ins(JC,  3'd0, 4'hF);
    imem[15] = ins(NOP, 3'd0, 4'h0);
    do_reset();
    step(8);
    checks++; if ({port_dout, carry_flag, zero_flag} !== {4'hE, 1'b1, 1'b0}) begin
      fails++; $display("FAIL shl: got A=%0h C=%b Z=%b expected A=e C=1 Z=0",
                        port_dout, carry_flag, zero_flag); end
    step(4);
    checks++; if ({port_dout, carry_flag, zero_flag} !== {4'h0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL sub_zero: got A=%0h C=%b Z=%b expected A=0 C=0 Z=1",
                        port_dout, carry_flag, zero_flag); end
    step(2);
    checks++; if (imem_addr !== 4'hA) begin
      fails++; $display("FAIL jz_taken: got %0h expected a", imem_addr); end
    step(4);
    checks++; if ({port_dout, carry_flag, zero_flag} !== {4'hE, 1'b1, 1'b0}) begin
      fails++; $display("FAIL sub_borrow: got A=%0h C=%b Z=%b expected A=e C=1 Z=0",
                        port_dout, carry_flag, zero_flag); end
    step(2);
    checks++; if (imem_addr !== 4'hF) begin
      fails++; $display("FAIL jc_taken: got %0h expected f", imem_addr); end
    step(2);
    checks++; if (imem_addr !== 4'h0) begin
      fails++; $display("FAIL pc_wrap: got %0h expected 0", imem_addr); end
  endtask

  task automatic test_logic();
    clear_imem();
    imem[0]  = ins(LDI, 3'd0, 4'h6);
    imem[1]  = ins(ST,  3'd2, 4'h0);
    imem[2]  = ins(LDI, 3'd0, 4'hC);
    imem[3]  = ins(AND, 3'd2, 4'h0);
    imem[4]  = ins(OR,  3'd2, 4'h0);
    imem[5]  = ins(SHR, 3'd0, 4'h0);
    imem[6]  = ins(SHR, 3'd0, 4'h0);
    imem[7]  = ins(JZ,  3'd0, 4'h0);
    imem[8]  = ins(MOV, 3'd2, 4'h0);
    imem[9]  = ins(LDI, 3'd0, 4'h0);
    imem[10] = ins(JMP, 3'd0, 4'hD);
    imem[13] = ins(HLT, 3'd0, 4'h0);
    do_reset();
    step(8);
    checks++; if ({port_dout, zero_flag} !== {4'h4, 1'b0}) begin
      fails++; $display("FAIL and: got A=%0h Z=%b expected A=4 Z=0", port_dout, zero_flag); end
    step(2);
    checks++; if (port_dout !== 4'h6) begin
      fails++; $display("FAIL or: got %0h expected 6", port_dout); end
    step(2);
    checks++; if ({port_dout, carry_flag} !== {4'h3, 1'b0}) begin
      fails++; $display("FAIL shr0: got A=%0h C=%b expected A=3 C=0", port_dout, carry_flag); end
    step(2);
    checks++; if ({port_dout, carry_flag} !== {4'h1, 1'b1}) begin
      fails++; $display("FAIL shr1: got A=%0h C=%b expected A=1 C=1", port_dout, carry_flag); end
    step(2);
    checks++; if (imem_addr !== 4'h8) begin
      fails++; $display("FAIL jz_not_taken: got %0h expected 8", imem_addr); end
    step(2);
    checks++; if (port_dout !== 4'h6) begin
      fails++; $display("FAIL mov: got %0h expected 6", port_dout); end
    step(2);
    checks++; if ({port_dout, carry_flag, zero_flag} !== {4'h0, 1'b1, 1'b1}) begin
      fails++; $display("FAIL ldi_zero: got A=%0h C=%b Z=%b expected A=0 C=1 Z=1",
                        port_dout, carry_flag, zero_flag); end
    step(2);
    checks++; if (imem_addr !== 4'hD) begin
      fails++; $display("FAIL jmp: got %0h expected d", imem_addr); end
    step(2);
    checks++; if (halted !== 1'b1) begin
      fails++; $display("FAIL halt_after_jmp: got %b expected 1", halted); end
  endtask

  task automatic test_out();
    int cnt;
    logic ok;
    clear_imem();
    imem[0] = ins(LDI, 3'd0, 4'h7);
    imem[1] = ins(OUT, 3'd0, 4'h5);
    imem[2] = ins(LDI, 3'd0, 4'h1);
    imem[3] = ins(HLT, 3'd0, 4'h0);
    do_reset();
    port_ack = 1'b1;
    step(2);
    checks++; if (port_dout !== 4'h7) begin
      fails++; $display("FAIL out_ldi: got %0h expected 7", port_dout); end
    step(2);
    run_io(4, 3'd5, 1'b1, cnt, ok);
    checks++; if (cnt !== 4) begin
      fails++; $display("FAIL out_wr_cycles: got %0d expected 4", cnt); end
    checks++; if (ok !== 1'b1) begin
      fails++; $display("FAIL out_port_signals: got %b expected 1", ok); end
    checks++; if ({io_err, imem_addr} !== {1'b0, 4'h2}) begin
      fails++; $display("FAIL out_done: got err=%b pc=%0h expected err=0 pc=2", io_err, imem_addr); end
    step(2);
    checks++; if (port_dout !== 4'h1) begin
      fails++; $display("FAIL out_continue: got %0h expected 1", port_dout); end
  endtask

  task automatic test_in_timeout();
    int cnt;
    logic ok;
    clear_imem();
    imem[0] = ins(LDI, 3'd0, 4'h0);
    imem[1] = ins(IN,  3'd0, 4'h2);
    imem[2] = ins(LDI, 3'd0, 4'h4);
    imem[3] = ins(HLT, 3'd0, 4'h0);
    port_din = 4'h5;
    do_reset();
    step(2);
    run_io(0, 3'd2, 1'b0, cnt, ok);
    checks++; if (cnt !== IO_TIMEOUT) begin
      fails++; $display("FAIL in_timeout_cycles: got %0d expected %0d", cnt, IO_TIMEOUT); end
    checks++; if (ok !== 1'b1) begin
      fails++; $display("FAIL in_timeout_signals: got %b expected 1", ok); end
    checks++; if ({io_err, port_dout, zero_flag, imem_addr} !== {1'b1, 4'h0, 1'b1, 4'h2}) begin
      fails++; $display("FAIL in_timeout_state: got err=%b A=%0h Z=%b pc=%0h expected err=1 A=0 Z=1 pc=2",
                        io_err, port_dout, zero_flag, imem_addr); end
    step(2);
    checks++; if ({io_err, port_dout} !== {1'b1, 4'h4}) begin
      fails++; $display("FAIL in_timeout_continue: got err=%b A=%0h expected err=1 A=4", io_err, port_dout); end
    do_reset();
    checks++; if (io_err !== 1'b0) begin
      fails++; $display("FAIL io_err_reset: got %b expected 0", io_err); end
  endtask

  task automatic test_in_ack();
    int cnt;
    logic ok;
    clear_imem();
    imem[0] = ins(LDI, 3'd0, 4'h9);
    imem[1] = ins(IN,  3'd0, 4'h3);
    imem[2] = ins(IN,  3'd0, 4'h6);
    imem[3] = ins(HLT, 3'd0, 4'h0);
    port_din = 4'h0;
    do_reset();
    step(2);
    run_io(1, 3'd3, 1'b0, cnt, ok);
    checks++; if ({cnt == 1, ok} !== 2'b11) begin
      fails++; $display("FAIL in_ack_fast: got cycles=%0d ok=%b expected cycles=1 ok=1", cnt, ok); end
    checks++; if ({port_dout, zero_flag, imem_addr} !== {4'h0, 1'b1, 4'h2}) begin
      fails++; $display("FAIL in_ack_fast_state: got A=%0h Z=%b pc=%0h expected A=0 Z=1 pc=2",
                        port_dout, zero_flag, imem_addr); end
    port_din = 4'hA;
    run_io(IO_TIMEOUT, 3'd6, 1'b0, cnt, ok);
    checks++; if ({cnt == IO_TIMEOUT, ok} !== 2'b11) begin
      fails++; $display("FAIL in_ack_last: got cycles=%0d ok=%b expected cycles=%0d ok=1",
                        cnt, ok, IO_TIMEOUT); end
    checks++; if ({io_err, port_dout, zero_flag, imem_addr} !== {1'b0, 4'hA, 1'b0, 4'h3}) begin
      fails++; $display("FAIL in_ack_last_state: got err=%b A=%0h Z=%b pc=%0h expected err=0 A=a Z=0 pc=3",
                        io_err, port_dout, zero_flag, imem_addr); end
  endtask

  task automatic test_reset_mid_io();
    clear_imem();
    imem[0] = ins(IN, 3'd0, 4'h1);
    do_reset();
    step(2);
    checks++; if (port_rd !== 1'b1) begin
      fails++; $display("FAIL mid_io_rd_up: got %b expected 1", port_rd); end
    step(1);
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({port_rd, imem_addr, io_err} !== {1'b0, 4'h0, 1'b0}) begin
      fails++; $display("FAIL mid_io_reset: got rd=%b pc=%0h err=%b expected rd=0 pc=0 err=0",
                        port_rd, imem_addr, io_err); end
    reset = 1'b0;
    step(3);
    checks++; if (io_err !== 1'b0) begin
      fails++; $display("FAIL mid_io_err_stays: got %b expected 0", io_err); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_jz();
    test_logic();
    test_out();
    test_in_timeout();
    test_in_ack();
    test_reset_mid_io();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
